apb_i2c_regs: RTL and testbench
===============================

# apb_i2c_regs

Parametrised APB slave register file and data buffer for the I2C master. Decodes APB accesses into configuration registers (prescale, slave address, command), buffers transmit and receive bytes in small FIFOs toward the I2C core, stretches APB transfers with wait states on FIFO full/empty, and reports errors through PSLVERR and a maskable interrupt. It sits between the APB bus and the I2C byte engine.

## Interface
- DATA_WIDTH, 8: APB data width; register fields occupy bits [7:0], upper bits read 0 and are ignored on write.
- ADDR_WIDTH, 8: PADDR width; decode compares the full PADDR.
- TX_DEPTH, 4: TX FIFO entries, power of 2, ≥2.
- RX_DEPTH, 4: RX FIFO entries, power of 2, ≥2.
- WAIT_MAX, 15: maximum stall cycles before a blocked access errors out, ≥1.
- PRESCALE_RST, 0: reset value of PRESCALE.
- PCLK  in  1  clock; all logic on rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- PSEL, PENABLE, PWRITE  in  1 each  APB control.
- PADDR  in  ADDR_WIDTH  register index.
- PWDATA  in  DATA_WIDTH  write data.
- PRDATA  out  DATA_WIDTH  read data, valid when PREADY=1; 0 otherwise.
- PREADY  out  1  transfer completes this cycle.
- PSLVERR  out  1  error response, valid only with PREADY=1.
- prescale_reg, address_reg, command_reg  out  8 each  configuration to core.
- cmd_go  out  1  one-cycle pulse: COMMAND written with bit0=1.
- tx_data  out  8 / tx_valid  out  1 / tx_ready  in  1  TX FIFO head to core; pop when valid&ready.
- rx_data  in  8 / rx_valid  in  1 / rx_ready  out  1  core to RX FIFO; push when valid&ready; rx_ready = !rx_full.
- core_busy  in  1 / core_done  in  1 (pulse) / core_ack_err  in  1 (pulse)  core status.
- irq  out  1  |(IRQ_STAT & IRQ_EN), registered.

## Operation
- Register map (PADDR): 1 PRESCALE RW; 2 ADDRESS RW; 3 STATUS RO; 4 TXDATA WO (push); 5 RXDATA RO (pop); 6 COMMAND RW; 7 IRQ_EN RW [3:0]; 8 IRQ_STAT RW1C [3:0]. Any other address: PREADY=1 with no stall, PSLVERR=1, no side effect, PRDATA=0.
- Write to STATUS or RXDATA: PSLVERR=1, ignored. Read of TXDATA: PRDATA=0, OKAY.
- STATUS = {0,0,ack_err_seen, core_busy, rx_empty, rx_full, tx_empty, tx_full} (bit7..0); ack_err_seen = IRQ_STAT[3].
- COMMAND: bits[7:2] stored; bit0 (GO) → cmd_go pulse; bit1 (FLUSH) empties both FIFOs; bits 0,1 always stored/read as 0.
- IRQ_STAT sticky bits: [0] TX FIFO transitions to empty, [1] RX push accepted, [2] core_done, [3] core_ack_err. Writing 1 clears; a set event in the same cycle wins over clear.
- TX write when tx_full, or RXDATA read when rx_empty: PREADY held 0 (stall). Completes normally the first cycle the condition clears. After WAIT_MAX stall cycles, the next cycle gives PREADY=1, PSLVERR=1, no push/pop, PRDATA=0.
- FIFOs: occupancy counters 0..DEPTH; push when not full, pop when not empty, simultaneous push/pop leaves count unchanged; pointers wrap modulo DEPTH. Full blocks push even with a same-cycle pop. FLUSH takes priority over same-cycle push/pop.

## Timing
- Setup phase (PSEL=1, PENABLE=0): no effect. Access phase: zero-wait for all mapped non-blocked accesses.
- Write/push/pop/W1C take effect at the PCLK edge where PSEL&PENABLE&PREADY; new values visible the next cycle.
- PRDATA and PSLVERR are combinational during the access phase. RXDATA returns the FIFO head at completion.
- Stall counter clears whenever PENABLE=0 or a transfer completes.
- tx_valid = !tx_empty; tx_data = head (combinational from storage).
- irq is registered: asserts 1 cycle after the status/enable change.
- Reset (any time, including mid-stall): prescale_reg=PRESCALE_RST; address_reg, command_reg, IRQ_EN, IRQ_STAT = 0; FIFOs empty (tx_valid=0, rx_ready=1); cmd_go=0, irq=0; stall counter 0; PREADY=0 and PSLVERR=0 outside an access phase.

## Test plan
- Reset, then write PRESCALE=0x3C and ADDRESS=0xA0, read both back → 0x3C, 0xA0, zero wait, PSLVERR=0; read STATUS → 0x0A.
- Push 4 bytes 0x11..0x44 with tx_ready=0 → STATUS tx_full=1; 5th write stalls; assert tx_ready 3 cycles later → 0x11 popped, 5th write completes with OKAY, order preserved.
- Read RXDATA with RX empty, no rx_valid → exactly WAIT_MAX (15) stall cycles, then PREADY=1, PSLVERR=1, PRDATA=0.
- Core pushes 0x5A while a RXDATA read is stalled → read completes next cycle with PRDATA=0x5A; IRQ_STAT[1]=1; with IRQ_EN=0x2, irq=1; write IRQ_STAT=0x2 → irq drops.
- Write COMMAND=0x81 → cmd_go pulses 1 cycle, COMMAND reads 0x80; write 0x02 with both FIFOs partly full → both empty next cycle.
- Access PADDR=0x09 and write STATUS → PSLVERR=1, no register changes; assert PRESET mid-stall → PREADY returns 0 and all outputs take their reset values.

Source files
------------

// File: rtl/apb_i2c_regs_if.sv
// APB bus bundle between an APB master and the I2C register block.
// PRDATA, PREADY and PSLVERR are driven by the slave.
interface apb_i2c_regs_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_i2c_regs.sv
// APB register file and TX/RX byte FIFOs for the I2C master.
// Blocked FIFO accesses stall with wait states and time out with PSLVERR.
module apb_i2c_regs #(
  parameter int         DATA_WIDTH   = 8,
  parameter int         ADDR_WIDTH   = 8,
  parameter int         TX_DEPTH     = 4,
  parameter int         RX_DEPTH     = 4,
  parameter int         WAIT_MAX     = 15,
  parameter logic [7:0] PRESCALE_RST = 8'h00
) (
  input  logic           PCLK,
  input  logic           PRESET,
  apb_i2c_regs_if.slave  apb,
  output logic [7:0]     prescale_reg,
  output logic [7:0]     address_reg,
  output logic [7:0]     command_reg,
  output logic           cmd_go,
  output logic [7:0]     tx_data,
  output logic           tx_valid,
  input  logic           tx_ready,
  input  logic [7:0]     rx_data,
  input  logic           rx_valid,
  output logic           rx_ready,
  input  logic           core_busy,
  input  logic           core_done,
  input  logic           core_ack_err,
  output logic           irq
);
  localparam int TXP = $clog2(TX_DEPTH);
  localparam int TXC = $clog2(TX_DEPTH + 1);
  localparam int RXP = $clog2(RX_DEPTH);
  localparam int RXC = $clog2(RX_DEPTH + 1);
  localparam int SW  = $clog2(WAIT_MAX + 1);

  localparam logic [ADDR_WIDTH-1:0] A_PRESCALE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_ADDRESS  = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS   = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] A_TXDATA   = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] A_RXDATA   = ADDR_WIDTH'(5);
  localparam logic [ADDR_WIDTH-1:0] A_COMMAND  = ADDR_WIDTH'(6);
  localparam logic [ADDR_WIDTH-1:0] A_IRQ_EN   = ADDR_WIDTH'(7);
  localparam logic [ADDR_WIDTH-1:0] A_IRQ_STAT = ADDR_WIDTH'(8);

  logic [7:0]     prescale_q, prescale_d, address_q, address_d, command_q, command_d;
  logic [3:0]     irq_en_q, irq_en_d, irq_stat_q, irq_stat_d;
  logic           cmd_go_q, cmd_go_d, irq_q, irq_d;
  logic [SW-1:0]  stall_q, stall_d;
  logic [7:0]     tx_mem_q [TX_DEPTH];
  logic [7:0]     tx_mem_d [TX_DEPTH];
  logic [TXP-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [TXC-1:0] tx_cnt_q, tx_cnt_d;
  logic [7:0]     rx_mem_q [RX_DEPTH];
  logic [7:0]     rx_mem_d [RX_DEPTH];
  logic [RXP-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [RXC-1:0] rx_cnt_q, rx_cnt_d;

  logic access_s, blocked_s, pready_s, err_s, mapped_s, wr_ok_s, rd_ok_s;
  logic tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
  logic tx_push_s, tx_pop_s, rx_push_s, rx_pop_s, flush_s;
  logic [7:0] wbyte_s, rd_byte_s, status_s;
  logic [3:0] irq_ev_s;

  assign tx_full_s  = (tx_cnt_q == TXC'(TX_DEPTH));
  assign tx_empty_s = (tx_cnt_q == TXC'(0));
  assign rx_full_s  = (rx_cnt_q == RXC'(RX_DEPTH));
  assign rx_empty_s = (rx_cnt_q == RXC'(0));
  assign status_s   = {2'b00, irq_stat_q[3], core_busy, rx_empty_s, rx_full_s, tx_empty_s, tx_full_s};
  assign wbyte_s    = apb.PWDATA[7:0];

  // Holding PRESET masks the bus so a reset mid-stall never completes a transfer.
  assign access_s  = apb.PSEL & apb.PENABLE & ~PRESET;
  assign blocked_s = access_s & ((apb.PWRITE & (apb.PADDR == A_TXDATA) & tx_full_s) |
                                 (~apb.PWRITE & (apb.PADDR == A_RXDATA) & rx_empty_s));
  assign pready_s  = access_s & (~blocked_s | (stall_q == SW'(WAIT_MAX)));
  assign err_s     = ~mapped_s | blocked_s |
                     (apb.PWRITE & ((apb.PADDR == A_STATUS) | (apb.PADDR == A_RXDATA)));
  assign wr_ok_s   = pready_s & ~err_s & apb.PWRITE;
  assign rd_ok_s   = pready_s & ~err_s & ~apb.PWRITE;

  assign tx_push_s = wr_ok_s & (apb.PADDR == A_TXDATA);
  assign tx_pop_s  = ~tx_empty_s & tx_ready;
  assign rx_push_s = rx_valid & ~rx_full_s;
  assign rx_pop_s  = rd_ok_s & (apb.PADDR == A_RXDATA);
  assign flush_s   = wr_ok_s & (apb.PADDR == A_COMMAND) & wbyte_s[1];

  // Address decode and read-data mux.
  always_comb begin
    mapped_s  = 1'b1;
    rd_byte_s = 8'h00;
    case (apb.PADDR)
      A_PRESCALE: rd_byte_s = prescale_q;
      A_ADDRESS:  rd_byte_s = address_q;
      A_STATUS:   rd_byte_s = status_s;
      A_TXDATA:   rd_byte_s = 8'h00;
      A_RXDATA:   rd_byte_s = rx_mem_q[rx_rp_q];
      A_COMMAND:  rd_byte_s = command_q;
      A_IRQ_EN:   rd_byte_s = {4'h0, irq_en_q};
      A_IRQ_STAT: rd_byte_s = {4'h0, irq_stat_q};
      default:    mapped_s  = 1'b0;
    endcase
  end

  // APB response outputs; PRDATA stays zero unless a read completes OKAY.
  always_comb begin
    apb.PRDATA = '0;
    if (rd_ok_s) begin
      apb.PRDATA[7:0] = rd_byte_s;
    end else begin
      apb.PRDATA[7:0] = 8'h00;
    end
    apb.PREADY  = pready_s;
    apb.PSLVERR = pready_s & err_s;
  end

  // Next state of configuration registers, interrupt logic and stall counter.
  always_comb begin
    prescale_d = prescale_q;
    address_d  = address_q;
    command_d  = command_q;
    irq_en_d   = irq_en_q;
    irq_stat_d = irq_stat_q;
    if (wr_ok_s) begin
      case (apb.PADDR)
        A_PRESCALE: prescale_d = wbyte_s;
        A_ADDRESS:  address_d  = wbyte_s;
        A_COMMAND:  command_d  = {wbyte_s[7:2], 2'b00};
        A_IRQ_EN:   irq_en_d   = wbyte_s[3:0];
        A_IRQ_STAT: irq_stat_d = irq_stat_q & ~wbyte_s[3:0];
        default:    prescale_d = prescale_q;
      endcase
    end else begin
      prescale_d = prescale_q;
    end
    // Set events are OR-ed in after the clear so they win.
    irq_stat_d = irq_stat_d | irq_ev_s;
    cmd_go_d   = wr_ok_s & (apb.PADDR == A_COMMAND) & wbyte_s[0];
    irq_d      = |(irq_stat_q & irq_en_q);
    if (access_s && !pready_s) begin
      stall_d = stall_q + SW'(1);
    end else begin
      stall_d = '0;
    end
  end

  // TX and RX FIFO pointer, occupancy and storage updates; flush overrides traffic.
  always_comb begin
    tx_mem_d = tx_mem_q;
    rx_mem_d = rx_mem_q;
    tx_wp_d  = tx_wp_q;
    tx_rp_d  = tx_rp_q;
    rx_wp_d  = rx_wp_q;
    rx_rp_d  = rx_rp_q;
    if (flush_s) begin
      tx_wp_d  = '0;
      tx_rp_d  = '0;
      tx_cnt_d = '0;
      rx_wp_d  = '0;
      rx_rp_d  = '0;
      rx_cnt_d = '0;
    end else begin
      if (tx_push_s) begin
        tx_mem_d[tx_wp_q] = wbyte_s;
        tx_wp_d = tx_wp_q + TXP'(1);
      end else begin
        tx_wp_d = tx_wp_q;
      end
      if (tx_pop_s) begin
        tx_rp_d = tx_rp_q + TXP'(1);
      end else begin
        tx_rp_d = tx_rp_q;
      end
      if (rx_push_s) begin
        rx_mem_d[rx_wp_q] = rx_data;
        rx_wp_d = rx_wp_q + RXP'(1);
      end else begin
        rx_wp_d = rx_wp_q;
      end
      if (rx_pop_s) begin
        rx_rp_d = rx_rp_q + RXP'(1);
      end else begin
        rx_rp_d = rx_rp_q;
      end
      tx_cnt_d = tx_cnt_q + TXC'(tx_push_s) - TXC'(tx_pop_s);
      rx_cnt_d = rx_cnt_q + RXC'(rx_push_s) - RXC'(rx_pop_s);
    end
    irq_ev_s = {core_ack_err, core_done, rx_push_s,
                (tx_cnt_q != TXC'(0)) && (tx_cnt_d == TXC'(0))};
  end

  // State registers.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      prescale_q <= PRESCALE_RST;
      address_q  <= 8'h00;
      command_q  <= 8'h00;
      irq_en_q   <= 4'h0;
      irq_stat_q <= 4'h0;
      cmd_go_q   <= 1'b0;
      irq_q      <= 1'b0;
      stall_q    <= '0;
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      tx_cnt_q   <= '0;
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      rx_cnt_q   <= '0;
      for (int i = 0; i < TX_DEPTH; i++) tx_mem_q[i] <= 8'h00;
      for (int i = 0; i < RX_DEPTH; i++) rx_mem_q[i] <= 8'h00;
    end else begin
      prescale_q <= prescale_d;
      address_q  <= address_d;
      command_q  <= command_d;
      irq_en_q   <= irq_en_d;
      irq_stat_q <= irq_stat_d;
      cmd_go_q   <= cmd_go_d;
      irq_q      <= irq_d;
      stall_q    <= stall_d;
      tx_wp_q    <= tx_wp_d;
      tx_rp_q    <= tx_rp_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_wp_q    <= rx_wp_d;
      rx_rp_q    <= rx_rp_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_mem_q   <= tx_mem_d;
      rx_mem_q   <= rx_mem_d;
    end
  end

  assign prescale_reg = prescale_q;
  assign address_reg  = address_q;
  assign command_reg  = command_q;
  assign cmd_go       = cmd_go_q;
  assign irq          = irq_q;
  assign tx_valid     = ~tx_empty_s;
  assign tx_data      = tx_mem_q[tx_rp_q];
  assign rx_ready     = ~rx_full_s;
endmodule

// File: tb/tb_apb_i2c_regs.sv
// Directed testbench for apb_i2c_regs: register access, FIFO stalls and
// timeouts, interrupts, command side effects, error responses and reset.
module tb_apb_i2c_regs;
  logic       PCLK = 1'b0;
  logic       PRESET;
  logic [7:0] prescale_reg, address_reg, command_reg, tx_data, rx_data;
  logic       cmd_go, tx_valid, tx_ready, rx_valid, rx_ready;
  logic       core_busy, core_done, core_ack_err, irq;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] rd;
  logic       er;
  int         ns;

  apb_i2c_regs_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

  apb_i2c_regs dut (
    .PCLK(PCLK), .PRESET(PRESET), .apb(bus),
    .prescale_reg(prescale_reg), .address_reg(address_reg), .command_reg(command_reg),
    .cmd_go(cmd_go), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .core_busy(core_busy), .core_done(core_done), .core_ack_err(core_ack_err), .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  task automatic apb_xfer(input logic [7:0] addr, input logic wr, input logic [7:0] wdata,
                          output logic [7:0] rdata, output logic err, output int nstall);
    bit done;
    nstall = 0; done = 1'b0; rdata = 8'h00; err = 1'b0;
    @(posedge PCLK); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr; bus.PADDR = addr; bus.PWDATA = wdata;
    @(posedge PCLK); #1 bus.PENABLE = 1'b1;
    while (!done) begin
      @(negedge PCLK);
      if (bus.PREADY === 1'b1) begin
        rdata = bus.PRDATA; err = bus.PSLVERR; done = 1'b1;
      end else if (nstall >= 40) begin
        checks++; errors++;
        $display("FAIL apb_timeout: addr %h still stalled after %0d cycles", addr, nstall);
        done = 1'b1;
      end else begin
        nstall++;
      end
    end
    @(posedge PCLK); #1 bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = 8'h00; bus.PWDATA = 8'h00;
    tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    core_busy = 1'b0; core_done = 1'b0; core_ack_err = 1'b0;
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;
    @(negedge PCLK);
    checks++; if (bus.PREADY !== 1'b0) begin errors++; $display("FAIL rst_pready: got %b expected 0", bus.PREADY); end
    checks++; if (prescale_reg !== 8'h00) begin errors++; $display("FAIL rst_prescale: got %h expected 00", prescale_reg); end
    checks++; if ({tx_valid, rx_ready, irq, cmd_go} !== 4'b0100) begin errors++; $display("FAIL rst_flags: got %b expected 0100", {tx_valid, rx_ready, irq, cmd_go}); end
  endtask

  task automatic test_config();
    apb_xfer(8'h01, 1'b1, 8'h3C, rd, er, ns);
    checks++; if ({er, ns[7:0]} !== 9'h000) begin errors++; $display("FAIL wr_prescale: err/stalls got %b/%0d expected 0/0", er, ns); end
    apb_xfer(8'h02, 1'b1, 8'hA0, rd, er, ns);
    apb_xfer(8'h01, 1'b0, 8'h00, rd, er, ns);
    checks++; if (rd !== 8'h3C || er !== 1'b0 || ns != 0) begin errors++; $display("FAIL rd_prescale: got %h/%b/%0d expected 3c/0/0", rd, er, ns); end
    apb_xfer(8'h02, 1'b0, 8'h00, rd, er, ns);
    checks++; if (rd !== 8'hA0 || er !== 1'b0 || ns != 0) begin errors++; $display("FAIL rd_address: got %h/%b/%0d expected a0/0/0", rd, er, ns); end
    apb_xfer(8'h03, 1'b0, 8'h00, rd, er, ns);
    checks++; if (rd !== 8'h0A) begin errors++; $display("FAIL rd_status_init: got %h expected 0a", rd); end
    checks++; if (prescale_reg !== 8'h3C || address_reg !== 8'hA0) begin errors++; $display("FAIL cfg_outputs: got %h %h expected 3c a0", prescale_reg, address_reg); end
  endtask

  task automatic test_tx_stall();
    logic [7:0] exp_q [4] = '{8'h22, 8'h33, 8'h44, 8'h55};
    tx_ready = 1'b0;
    for (int i = 1; i <= 4; i++) apb_xfer(8'h04, 1'b1, 8'(i * 17), rd, er, ns);
    apb_xfer(8'h03, 1'b0, 8'h00, rd, er, ns);
    checks++; if (rd !== 8'h09) begin errors++; $display("FAIL status_tx_full: got %h expected 09", rd); end
    checks++; if (tx_data !== 8'h11 || tx_valid !== 1'b1) begin errors++; $display("FAIL tx_head: got %h/%b expected 11/1", tx_data, tx_valid); end
    fork
      apb_xfer(8'h04, 1'b1, 8'h55, rd, er, ns);
      begin repeat (4) @(posedge PCLK); #1 tx_ready = 1'b1; @(posedge PCLK); #1 tx_ready = 1'b0; end
    join
    checks++; if (ns != 3 || er !== 1'b0) begin errors++; $display("FAIL tx_stall_write: stalls/err got %0d/%b expected 3/0", ns, er); end
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      checks++; if (tx_data !== exp_q[i] || tx_valid !== 1'b1) begin errors++; $display("FAIL tx_order%0d: got %h/%b expected %h/1", i, tx_data, tx_valid, exp_q[i]); end
      tx_ready = 1'b1;
      @(posedge PCLK); #1 tx_ready = 1'b0;
    end
    @(negedge PCLK);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_drained: got %b expected 0", tx_valid); end
  endtask

  task automatic test_rx_timeout();
    apb_xfer(8'h05, 1'b0, 8'h00, rd, er, ns);
    checks++; if (ns != 15) begin errors++; $display("FAIL rx_timeout_stalls: got %0d expected 15", ns); end
    checks++; if (er !== 1'b1 || rd !== 8'h00) begin errors++; $display("FAIL rx_timeout_resp: got err %b data %h expected 1 00", er, rd); end
  endtask

  task automatic test_rx_irq();
    fork
      apb_xfer(8'h05, 1'b0, 8'h00, rd, er, ns);
      begin repeat (4) @(posedge PCLK); #1 rx_data = 8'h5A; rx_valid = 1'b1; @(posedge PCLK); #1 rx_valid = 1'b0; end
    join
    checks++; if (rd !== 8'h5A || er !== 1'b0 || ns != 3) begin errors++; $display("FAIL rx_late_push: got %h/%b/%0d expected 5a/0/3", rd, er, ns); end
    apb_xfer(8'h08, 1'b0, 8'h00, rd, er, ns);
    checks++; if (rd !== 8'h03) begin errors++; $display("FAIL irq_stat_rx: got %h expected 03", rd); end
    apb_xfer(8'h07, 1'b1, 8'h02, rd, er, ns);
    repeat (2) @(posedge PCLK); #1;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rx_on: got %b expected 1", irq); end
    apb_xfer(8'h08, 1'b1, 8'h02, rd, er, ns);
    repeat (2) @(posedge PCLK); #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_rx_off: got %b expected 0", irq); end
    apb_xfer(8'h08, 1'b0, 8'h00, rd, er, ns);
    checks++; if (rd !== 8'h01) begin errors++; $display("FAIL irq_stat_w1c: got %h expected 01", rd); end
  endtask

  task automatic test_command();
    apb_xfer(8'h06, 1'b1, 8'h81, rd, er, ns);
    checks++; if (cmd_go !== 1'b1) begin errors++; $display("FAIL cmd_go_pulse: got %b expected 1", cmd_go); end
    @(posedge PCLK); #1;
    checks++; if (cmd_go !== 1'b0) begin errors++; $display("FAIL cmd_go_end: got %b expected 0", cmd_go); end
    apb_xfer(8'h06, 1'b0, 8'h00, rd, er, ns);
    checks++; if (rd !== 8'h80 || command_reg !== 8'h80) begin errors++; $display("FAIL cmd_read: got %h/%h expected 80/80", rd, command_reg); end
    apb_xfer(8'h04, 1'b1, 8'hA1, rd, er, ns);
    apb_xfer(8'h04, 1'b1, 8'hA2, rd, er, ns);
    @(posedge PCLK); #1 rx_data = 8'h77; rx_valid = 1'b1;
    @(posedge PCLK); #1 rx_valid = 1'b0;
    apb_xfer(8'h03, 1'b0, 8'h00, rd, er, ns);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL status_partial: got %h expected 00", rd); end
    apb_xfer(8'h06, 1'b1, 8'h02, rd, er, ns);
    checks++; if (cmd_go !== 1'b0 || tx_valid !== 1'b0) begin errors++; $display("FAIL flush_now: go/tx_valid got %b/%b expected 0/0", cmd_go, tx_valid); end
    apb_xfer(8'h03, 1'b0, 8'h00, rd, er, ns);
    checks++; if (rd !== 8'h0A || command_reg !== 8'h00) begin errors++; $display("FAIL flush_status: got %h/%h expected 0a/00", rd, command_reg); end
  endtask

  task automatic test_errors();
    apb_xfer(8'h09, 1'b0, 8'h00, rd, er, ns);
    checks++; if (er !== 1'b1 || rd !== 8'h00 || ns != 0) begin errors++; $display("FAIL unmapped_rd: got %b/%h/%0d expected 1/00/0", er, rd, ns); end
    apb_xfer(8'h00, 1'b1, 8'h12, rd, er, ns);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL unmapped_wr: got %b expected 1", er); end
    apb_xfer(8'h03, 1'b1, 8'hFF, rd, er, ns);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL status_wr: got %b expected 1", er); end
    apb_xfer(8'h05, 1'b1, 8'h33, rd, er, ns);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL rxdata_wr: got %b expected 1", er); end
    apb_xfer(8'h04, 1'b0, 8'h00, rd, er, ns);
    checks++; if (er !== 1'b0 || rd !== 8'h00) begin errors++; $display("FAIL txdata_rd: got %b/%h expected 0/00", er, rd); end
    apb_xfer(8'h01, 1'b0, 8'h00, rd, er, ns);
    checks++; if (rd !== 8'h3C || tx_valid !== 1'b0) begin errors++; $display("FAIL no_side_effect: got %h/%b expected 3c/0", rd, tx_valid); end
    core_busy = 1'b1;
    @(posedge PCLK); #1 core_done = 1'b1; core_ack_err = 1'b1;
    @(posedge PCLK); #1 core_done = 1'b0; core_ack_err = 1'b0;
    apb_xfer(8'h03, 1'b0, 8'h00, rd, er, ns);
    checks++; if (rd !== 8'h3A) begin errors++; $display("FAIL status_core: got %h expected 3a", rd); end
    apb_xfer(8'h08, 1'b0, 8'h00, rd, er, ns);
    checks++; if (rd !== 8'h0F) begin errors++; $display("FAIL irq_stat_all: got %h expected 0f", rd); end
    apb_xfer(8'h07, 1'b1, 8'h08, rd, er, ns);
    repeat (2) @(posedge PCLK); #1;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_ackerr: got %b expected 1", irq); end
  endtask

  task automatic test_reset_midstall();
    @(posedge PCLK); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = 8'h05;
    @(posedge PCLK); #1 bus.PENABLE = 1'b1;
    repeat (3) @(negedge PCLK);
    checks++; if (bus.PREADY !== 1'b0) begin errors++; $display("FAIL midstall_pre: got %b expected 0", bus.PREADY); end
    #1 PRESET = 1'b1;
    #1;
    checks++; if (bus.PREADY !== 1'b0 || bus.PSLVERR !== 1'b0) begin errors++; $display("FAIL midstall_resp: got %b/%b expected 0/0", bus.PREADY, bus.PSLVERR); end
    checks++; if ({prescale_reg, address_reg, command_reg} !== 24'h000000) begin errors++; $display("FAIL midstall_regs: got %h %h %h expected 00 00 00", prescale_reg, address_reg, command_reg); end
    checks++; if ({tx_valid, rx_ready, irq, cmd_go} !== 4'b0100) begin errors++; $display("FAIL midstall_flags: got %b expected 0100", {tx_valid, rx_ready, irq, cmd_go}); end
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; core_busy = 1'b0;
    @(posedge PCLK); #1 PRESET = 1'b0;
    apb_xfer(8'h08, 1'b0, 8'h00, rd, er, ns);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL post_rst_irqstat: got %h expected 00", rd); end
    apb_xfer(8'h03, 1'b0, 8'h00, rd, er, ns);
    checks++; if (rd !== 8'h0A) begin errors++; $display("FAIL post_rst_status: got %h expected 0a", rd); end
  endtask

  initial begin
    test_reset();
    test_config();
    test_tx_stall();
    test_rx_timeout();
    test_rx_irq();
    test_command();
    test_errors();
    test_reset_midstall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
